// File: rtl/mult_pkg.sv
// Shared types and constants for the signed shift-add multiplier.
// MULT_FAST_SHIFT_EN selects the single-cycle CALC state set.
package mult_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

`ifdef MULT_FAST_SHIFT_EN
  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;
`else
  typedef enum logic [1:0] {StIdle, StAdd, StShift, StDone} state_e;
`endif

  function automatic int unsigned count_width(input int unsigned width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/adder_subtractor_nbit.sv
// Combinational ripple-carry adder/subtractor with a WIDTH+1 sign-extended result.
module adder_subtractor_nbit #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sub,
  output logic [WIDTH:0]   sum
);

  logic [WIDTH:0] a_ext;
  logic [WIDTH:0] b_ext;
  logic [WIDTH:0] carry;

  assign a_ext    = {A[WIDTH-1], A};
  // Subtraction as A + ~B + 1, with the +1 entering through the carry-in.
  assign b_ext    = {B[WIDTH-1], B} ^ {(WIDTH + 1){sub}};
  assign carry[0] = sub;

  for (genvar i = 0; i <= WIDTH; i++) begin : g_fa
    assign sum[i] = a_ext[i] ^ b_ext[i] ^ carry[i];
    if (i < WIDTH) begin : g_carry
      assign carry[i+1] = (a_ext[i] & b_ext[i]) | (a_ext[i] & carry[i]) |
                          (b_ext[i] & carry[i]);
    end
  end

endmodule

// File: rtl/signed_add_shift_mult.sv
// Sequential signed multiplier: add (subtract on the sign bit), then arithmetic shift.
// Define MULT_FAST_SHIFT_EN to merge add and shift into one CALC cycle.
module signed_add_shift_mult
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Run,
  input  logic [WIDTH-1:0]     Multiplicand,
  input  logic [WIDTH-1:0]     Multiplier,
  output logic [2*WIDTH-1:0]   Product,
  output logic                 X,
  output logic                 Busy,
  output logic                 Done
);

  localparam int unsigned CW = count_width(WIDTH);
  localparam logic [CW-1:0] LastCount = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             x_q, x_d;
  logic [CW-1:0]    count_q, count_d;

  logic             last_step;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   acc;

  assign last_step = (count_q == LastCount);

  // The final multiplier bit carries negative weight, so that step subtracts.
  adder_subtractor_nbit #(
    .WIDTH(WIDTH)
  ) u_addsub (
    .A  (a_q),
    .B  (s_q),
    .sub(last_step),
    .sum(sum)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    x_d     = x_q;
    count_d = count_q;
    acc     = b_q[0] ? sum : {x_q, a_q};

    unique case (state_q)
      StIdle: begin
        if (Run) begin
          a_d     = '0;
          x_d     = 1'b0;
          b_d     = Multiplier;
          s_d     = Multiplicand;
          count_d = '0;
`ifdef MULT_FAST_SHIFT_EN
          state_d = StCalc;
`else
          state_d = StAdd;
`endif
        end
      end
`ifdef MULT_FAST_SHIFT_EN
      StCalc: begin
        x_d     = acc[WIDTH];
        a_d     = acc[WIDTH:1];
        b_d     = {acc[0], b_q[WIDTH-1:1]};
        count_d = count_q + CW'(1);
        state_d = last_step ? StDone : StCalc;
      end
`else
      StAdd: begin
        {x_d, a_d} = acc;
        state_d    = StShift;
      end
      StShift: begin
        a_d     = {x_q, a_q[WIDTH-1:1]};
        b_d     = {a_q[0], b_q[WIDTH-1:1]};
        count_d = count_q + CW'(1);
        state_d = last_step ? StDone : StAdd;
      end
`endif
      StDone: begin
        if (!Run) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      x_q     <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      x_q     <= x_d;
      count_q <= count_d;
    end
  end

  assign Product = {a_q, b_q};
  assign X       = x_q;
  assign Busy    = (state_q != StIdle) && (state_q != StDone);
  assign Done    = (state_q == StDone);

endmodule

// File: tb/tb_signed_add_shift_mult.sv
// Randomised self-checking bench for signed_add_shift_mult against integer multiplication.
module tb_signed_add_shift_mult;

  localparam int W = 8;
`ifdef MULT_FAST_SHIFT_EN
  localparam int ExpLat = W + 1;
`else
  localparam int ExpLat = 2 * W + 1;
`endif

  logic           Clk = 1'b0;
  logic           Reset = 1'b1;
  logic           Run = 1'b0;
  logic [W-1:0]   Multiplicand = '0;
  logic [W-1:0]   Multiplier = '0;
  logic [2*W-1:0] Product;
  logic           X;
  logic           Busy;
  logic           Done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 Clk = ~Clk;

  signed_add_shift_mult #(
    .WIDTH(W)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Run         (Run),
    .Multiplicand(Multiplicand),
    .Multiplier  (Multiplier),
    .Product     (Product),
    .X           (X),
    .Busy        (Busy),
    .Done        (Done)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] s, input logic [W-1:0] b);
    int si;
    int bi;
    int p;
    si = $signed(s);
    bi = $signed(b);
    p  = si * bi;
    return p[2*W-1:0];
  endfunction

  // Starts a multiply from IDLE, scrambles operands while it runs, returns edges to Done.
  task automatic do_mult(input logic [W-1:0] s, input logic [W-1:0] b, output int lat);
    Multiplicand = s;
    Multiplier   = b;
    Run          = 1'b1;
    @(posedge Clk); #1;
    lat = 1;
    Run = 1'b0;
    while (!Done && lat < 100) begin
      Multiplicand = W'($urandom);
      Multiplier   = W'($urandom);
      @(posedge Clk); #1;
      lat++;
    end
  endtask

  task automatic mult_and_check(input string tag, input logic [W-1:0] s, input logic [W-1:0] b,
                                input logic [2*W-1:0] exp);
    int lat;
    do_mult(s, b, lat);
    check({tag, "_lat"}, 64'(lat), 64'(ExpLat));
    check({tag, "_prod"}, 64'(Product), 64'(exp));
    check({tag, "_x"}, 64'(X), 64'(exp[2*W-1]));
    @(posedge Clk); #1;
    check({tag, "_idle"}, 64'({Busy, Done}), 64'(0));
    check({tag, "_hold"}, 64'(Product), 64'(exp));
  endtask

  initial begin
    int done_edge;
    int restarted;
    logic [2*W-1:0] exp;
    logic [W-1:0] rs, rb;

    repeat (2) @(posedge Clk);
    #1;
    check("rst_prod", 64'(Product), 64'(0));
    check("rst_flags", 64'({X, Busy, Done}), 64'(0));
    Reset = 1'b0;

    // Directed cases with hand-computed products
    mult_and_check("d_7x59", 8'h07, 8'h3B, 16'h019D);
    mult_and_check("d_m7x59", 8'hF9, 8'h3B, 16'hFE63);
    mult_and_check("d_7xm59", 8'h07, 8'hC5, 16'hFE63);
    mult_and_check("d_minxmin", 8'h80, 8'h80, 16'h4000);
    mult_and_check("d_maxxmin", 8'h7F, 8'h80, 16'hC080);
    mult_and_check("d_m1xm1", 8'hFF, 8'hFF, 16'h0001);

    // Reset on the sixth edge of a multiply
    Multiplicand = 8'h35;
    Multiplier   = 8'hA7;
    Run          = 1'b1;
    @(posedge Clk); #1;
    Run = 1'b0;
    repeat (4) @(posedge Clk);
    #1;
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    check("midrst_prod", 64'(Product), 64'(0));
    check("midrst_flags", 64'({X, Busy, Done}), 64'(0));
    mult_and_check("after_rst", 8'h35, 8'hA7, ref_prod(8'h35, 8'hA7));

    // Reset wins over Run
    Reset = 1'b1;
    Run   = 1'b1;
    @(posedge Clk); #1;
    check("rst_run_busy", 64'({Busy, Done}), 64'(0));
    Reset = 1'b0;
    Run   = 1'b0;

    // Run held for 40 cycles: one multiply only
    Multiplicand = 8'h93;
    Multiplier   = 8'h2D;
    exp          = ref_prod(8'h93, 8'h2D);
    Run          = 1'b1;
    done_edge    = 0;
    restarted    = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge Clk); #1;
      if (Done && done_edge == 0) done_edge = i;
      if (done_edge != 0 && (!Done || Busy)) restarted = 1;
    end
    check("held_lat", 64'(done_edge), 64'(ExpLat));
    check("held_oneshot", 64'(restarted), 64'(0));
    check("held_prod", 64'(Product), 64'(exp));
    Run = 1'b0;
    @(posedge Clk); #1;
    check("held_idle", 64'({Busy, Done}), 64'(0));
    check("held_keep", 64'(Product), 64'(exp));

    for (int k = 0; k < 200; k++) begin
      rs = W'($urandom);
      rb = W'($urandom);
      mult_and_check($sformatf("rnd%0d", k), rs, rb, ref_prod(rs, rb));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
